// File: rtl/control_pipeline.sv
// Control pipeline: EX/MEM/WB control-bundle registers with load-use stall,
// taken-branch flush, EX operand forwarding selects and a retire counter.
module control_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_alu_src,
  input  logic        id_branch,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_reg_write,
  input  logic [1:0]  id_alu_op,
  input  logic        mem_zero,
  output logic        ex_alu_src,
  output logic [1:0]  ex_alu_op,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic        mem_branch,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic [4:0]  mem_rd,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [31:0] retire_count
);

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } wb_stage_t;

  localparam ex_stage_t  EX_BUBBLE  = ex_stage_t'({$bits(ex_stage_t){1'b0}});
  localparam mem_stage_t MEM_BUBBLE = mem_stage_t'({$bits(mem_stage_t){1'b0}});
  localparam wb_stage_t  WB_BUBBLE  = wb_stage_t'({$bits(wb_stage_t){1'b0}});

  ex_stage_t  ex_r, ex_next_s, id_bundle_s;
  mem_stage_t mem_r, mem_next_s, ex_to_mem_s;
  wb_stage_t  wb_r, wb_next_s;
  logic [31:0] retire_count_r;
  logic        stall_s, flush_s;
  logic [1:0]  forward_a_s, forward_b_s;

  // Operand source for one EX register index; MEM producer is younger, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic ex_valid,
                                         input mem_stage_t m, input wb_stage_t w);
    logic [1:0] sel;
    if (!ex_valid) begin
      sel = 2'b00;
    end else if (m.valid && m.reg_write && (m.rd != 5'd0) && (m.rd == rs)) begin
      sel = 2'b10;
    end else if (w.valid && w.reg_write && (w.rd != 5'd0) && (w.rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Capture the decode bundle; non-valid decode becomes a clean bubble and
  // mem_to_reg is masked so an unknown value without reg_write latches as 0.
  always_comb begin
    id_bundle_s = EX_BUBBLE;
    if (id_valid) begin
      id_bundle_s.valid      = 1'b1;
      id_bundle_s.alu_src    = id_alu_src;
      id_bundle_s.alu_op     = id_alu_op;
      id_bundle_s.branch     = id_branch;
      id_bundle_s.mem_read   = id_mem_read;
      id_bundle_s.mem_write  = id_mem_write;
      id_bundle_s.mem_to_reg = id_mem_to_reg & id_reg_write;
      id_bundle_s.reg_write  = id_reg_write;
      id_bundle_s.rd         = id_rd;
      id_bundle_s.rs1        = id_rs1;
      id_bundle_s.rs2        = id_rs2;
    end else begin
      id_bundle_s = EX_BUBBLE;
    end
  end

  // Hazard detection and forwarding selects from current stage contents.
  always_comb begin
    stall_s = id_valid & ex_r.valid & ex_r.mem_read & (ex_r.rd != 5'd0) &
              ((ex_r.rd == id_rs1) | (ex_r.rd == id_rs2));
    flush_s = mem_r.valid & mem_r.branch & mem_zero;
    forward_a_s = fwd_sel(ex_r.rs1, ex_r.valid, mem_r, wb_r);
    forward_b_s = fwd_sel(ex_r.rs2, ex_r.valid, mem_r, wb_r);
  end

  // Next stage contents: flush bubbles EX and MEM, stall bubbles EX only.
  always_comb begin
    ex_to_mem_s = '{valid: ex_r.valid, branch: ex_r.branch, mem_read: ex_r.mem_read,
                    mem_write: ex_r.mem_write, mem_to_reg: ex_r.mem_to_reg,
                    reg_write: ex_r.reg_write, rd: ex_r.rd};
    wb_next_s   = '{valid: mem_r.valid, mem_to_reg: mem_r.mem_to_reg,
                    reg_write: mem_r.reg_write, rd: mem_r.rd};
    ex_next_s   = EX_BUBBLE;
    mem_next_s  = MEM_BUBBLE;
    if (flush_s) begin
      ex_next_s  = EX_BUBBLE;
      mem_next_s = MEM_BUBBLE;
    end else if (stall_s) begin
      ex_next_s  = EX_BUBBLE;
      mem_next_s = ex_to_mem_s;
    end else begin
      ex_next_s  = id_bundle_s;
      mem_next_s = ex_to_mem_s;
    end
  end

  // Stage registers and retire counter; reset empties the pipe without credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r           <= EX_BUBBLE;
      mem_r          <= MEM_BUBBLE;
      wb_r           <= WB_BUBBLE;
      retire_count_r <= 32'd0;
    end else begin
      ex_r           <= ex_next_s;
      mem_r          <= mem_next_s;
      wb_r           <= wb_next_s;
      retire_count_r <= retire_count_r + {31'd0, wb_r.valid};
    end
  end

  assign ex_alu_src    = ex_r.alu_src;
  assign ex_alu_op     = ex_r.alu_op;
  assign ex_rs1        = ex_r.rs1;
  assign ex_rs2        = ex_r.rs2;
  assign mem_branch    = mem_r.branch;
  assign mem_mem_read  = mem_r.mem_read;
  assign mem_mem_write = mem_r.mem_write;
  assign mem_rd        = mem_r.rd;
  assign wb_mem_to_reg = wb_r.mem_to_reg;
  assign wb_reg_write  = wb_r.reg_write;
  assign wb_rd         = wb_r.rd;
  assign stall         = stall_s;
  assign flush         = flush_s;
  assign forward_a     = forward_a_s;
  assign forward_b     = forward_b_s;
  assign retire_count  = retire_count_r;

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed scenarios plus a
// randomized run compared against an instruction-level pipeline model.
module tb_control_pipeline;

  logic        clk, rst_n;
  logic        id_valid, id_alu_src, id_branch, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_reg_write, mem_zero;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [1:0]  id_alu_op;
  logic        ex_alu_src, mem_branch, mem_mem_read, mem_mem_write;
  logic        wb_mem_to_reg, wb_reg_write, stall, flush;
  logic [1:0]  ex_alu_op, forward_a, forward_b;
  logic [4:0]  ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic [31:0] retire_count;

  int checks = 0;
  int failures = 0;

  control_pipeline dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .mem_zero(mem_zero), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_branch(mem_branch),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_rd(mem_rd),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .stall(stall), .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: a whole instruction record travels down the pipe.
  typedef struct packed {
    logic       valid, alu_src;
    logic [1:0] alu_op;
    logic       branch, mem_read, mem_write, mem_to_reg, reg_write;
    logic [4:0] rd, rs1, rs2;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  logic [31:0] m_retire;

  wire [65:0] dut_vec = {ex_alu_src, ex_alu_op, ex_rs1, ex_rs2, mem_branch, mem_mem_read,
                         mem_mem_write, mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd,
                         stall, flush, forward_a, forward_b, retire_count};

  function automatic logic model_stall();
    return id_valid && m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd0 &&
           (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
  endfunction

  function automatic logic model_flush();
    return m_mem.valid && m_mem.branch && mem_zero;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (!m_ex.valid) return 2'b00;
    if (m_mem.valid && m_mem.reg_write && m_mem.rd != 5'd0 && m_mem.rd == rs) return 2'b10;
    if (m_wb.valid && m_wb.reg_write && m_wb.rd != 5'd0 && m_wb.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [65:0] exp_vec();
    return {m_ex.alu_src, m_ex.alu_op, m_ex.rs1, m_ex.rs2, m_mem.branch, m_mem.mem_read,
            m_mem.mem_write, m_mem.rd, m_wb.mem_to_reg, m_wb.reg_write, m_wb.rd,
            model_stall(), model_flush(), model_fwd(m_ex.rs1), model_fwd(m_ex.rs2), m_retire};
  endfunction

  function automatic ins_t cur_id();
    ins_t i;
    i = '0;
    if (id_valid) begin
      i = {1'b1, id_alu_src, id_alu_op, id_branch, id_mem_read, id_mem_write,
           id_mem_to_reg & id_reg_write, id_reg_write, id_rd, id_rs1, id_rs2};
    end
    return i;
  endfunction

  task automatic model_clear();
    m_ex = '0; m_mem = '0; m_wb = '0; m_retire = 32'd0;
  endtask

  task automatic model_advance();
    logic st, fl;
    st = model_stall();
    fl = model_flush();
    if (m_wb.valid) m_retire = m_retire + 32'd1;
    m_wb = m_mem;
    if (fl) begin
      m_mem = '0; m_ex = '0;
    end else if (st) begin
      m_mem = m_ex; m_ex = '0;
    end else begin
      m_mem = m_ex; m_ex = cur_id();
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [1:0] op, input logic asrc,
                       input logic br, input logic mr, input logic mw, input logic m2r,
                       input logic rw);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_alu_op = op;
    id_alu_src = asrc; id_branch = br; id_mem_read = mr; id_mem_write = mw;
    id_mem_to_reg = m2r; id_reg_write = rw;
  endtask

  task automatic apply_nop();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; apply_nop(); mem_zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; apply_nop(); mem_zero = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 66'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_rtype();
    do_reset();
    apply(1'b1, 5'd5, 5'd1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); apply_nop(); #1;
    checks++;
    if ({ex_alu_op, ex_rs1, ex_rs2} !== {2'b10, 5'd1, 5'd2}) begin
      failures++; $display("FAIL rtype_ex: got %h expected %h", {ex_alu_op, ex_rs1, ex_rs2}, {2'b10, 5'd1, 5'd2});
    end
    tick(); #1;
    checks++;
    if (mem_rd !== 5'd5) begin
      failures++; $display("FAIL rtype_mem: got %0d expected 5", mem_rd);
    end
    tick(); #1;
    checks++;
    if ({wb_reg_write, wb_rd, retire_count} !== {1'b1, 5'd5, 32'd0}) begin
      failures++; $display("FAIL rtype_wb: got %b/%0d/%0d expected 1/5/0", wb_reg_write, wb_rd, retire_count);
    end
    tick(); #1;
    checks++;
    if ({wb_reg_write, retire_count} !== {1'b0, 32'd1}) begin
      failures++; $display("FAIL rtype_retire: got %b/%0d expected 0/1", wb_reg_write, retire_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(1'b1, 5'd3, 5'd1, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    apply(1'b1, 5'd6, 5'd3, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL lu_stall: got %b expected 1", stall);
    end
    tick(); #1;
    checks++;
    if ({ex_alu_op, ex_rs1, stall, mem_mem_read, mem_rd} !== {2'b00, 5'd0, 1'b0, 1'b1, 5'd3}) begin
      failures++; $display("FAIL lu_bubble: got %h expected %h",
                           {ex_alu_op, ex_rs1, stall, mem_mem_read, mem_rd}, {2'b00, 5'd0, 1'b0, 1'b1, 5'd3});
    end
    tick(); #1;
    checks++;
    if ({ex_alu_op, ex_rs1, forward_a} !== {2'b10, 5'd3, 2'b01}) begin
      failures++; $display("FAIL lu_forward: got %h expected %h", {ex_alu_op, ex_rs1, forward_a}, {2'b10, 5'd3, 2'b01});
    end
    apply_nop();
    tick(); tick(); tick();
  endtask

  task automatic test_forward();
    do_reset();
    apply(1'b1, 5'd4, 5'd1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 5'd7, 5'd1, 5'd4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); apply_nop(); #1;
    checks++;
    if ({forward_a, forward_b} !== {2'b00, 2'b10}) begin
      failures++; $display("FAIL fwd_mem: got %b%b expected 0010", forward_a, forward_b);
    end
    apply(1'b1, 5'd4, 5'd1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); apply_nop(); tick();
    apply(1'b1, 5'd7, 5'd1, 5'd4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); apply_nop(); #1;
    checks++;
    if ({forward_a, forward_b} !== {2'b00, 2'b01}) begin
      failures++; $display("FAIL fwd_wb: got %b%b expected 0001", forward_a, forward_b);
    end
    apply(1'b1, 5'd0, 5'd1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 5'd7, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); #1;
    checks++;
    if ({forward_a, forward_b} !== 4'b0000) begin
      failures++; $display("FAIL fwd_rd0: got %b%b expected 0000", forward_a, forward_b);
    end
    apply(1'b1, 5'd0, 5'd1, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    apply(1'b1, 5'd8, 5'd0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL stall_rd0: got %b expected 0", stall);
    end
  endtask

  task automatic test_branch();
    do_reset();
    apply(1'b1, 5'd0, 5'd1, 5'd2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 5'd8, 5'd1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 5'd9, 5'd4, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_zero = 1'b1; #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++; $display("FAIL br_flush: got %b expected 1", flush);
    end
    tick(); mem_zero = 1'b0; apply_nop(); #1;
    checks++;
    if ({ex_alu_op, ex_rs1, ex_rs2, mem_branch, mem_rd, wb_reg_write, wb_rd, flush} !== 22'd0) begin
      failures++; $display("FAIL br_bubbles: got %h expected 0",
                           {ex_alu_op, ex_rs1, ex_rs2, mem_branch, mem_rd, wb_reg_write, wb_rd, flush});
    end
    tick(); #1;
    checks++;
    if (retire_count !== 32'd1) begin
      failures++; $display("FAIL br_retire: got %0d expected 1", retire_count);
    end
    do_reset();
    apply(1'b1, 5'd0, 5'd1, 5'd2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 5'd8, 5'd1, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 5'd9, 5'd4, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_zero = 1'b0; #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++; $display("FAIL br_nt: got %b expected 0", flush);
    end
    tick(); #1;
    checks++;
    if ({mem_rd, ex_rs1, wb_rd} !== {5'd8, 5'd4, 5'd0}) begin
      failures++; $display("FAIL br_nt_adv: got %h expected %h", {mem_rd, ex_rs1, wb_rd}, {5'd8, 5'd4, 5'd0});
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    apply(1'b1, 5'd0, 5'd1, 5'd2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 5'd3, 5'd1, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    apply(1'b1, 5'd6, 5'd3, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_zero = 1'b1; #1;
    checks++;
    if ({stall, flush} !== 2'b11) begin
      failures++; $display("FAIL sf_both: got %b%b expected 11", stall, flush);
    end
    tick(); mem_zero = 1'b0; apply_nop(); #1;
    checks++;
    if ({ex_alu_op, ex_rs1, mem_mem_read, mem_rd, wb_reg_write, wb_rd, stall} !== 20'd0) begin
      failures++; $display("FAIL sf_bubbles: got %h expected 0",
                           {ex_alu_op, ex_rs1, mem_mem_read, mem_rd, wb_reg_write, wb_rd, stall});
    end
    tick(); #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL sf_no_reexec: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic hold;
    do_reset();
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        apply(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      mem_zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL rand_cycle %0d: got %h expected %h", n, dut_vec, exp_vec());
      end
      hold = model_stall() && !model_flush();
      tick();
    end
    mem_zero = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.retire_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.retire_count_r;
    m_retire = 32'hFFFF_FFFE;
    #1;
    checks++;
    if (retire_count !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL wrap_preload: got %h expected fffffffe", retire_count);
    end
    apply(1'b1, 5'd1, 5'd2, 5'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply(1'b1, 5'd2, 5'd2, 5'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); apply_nop(); tick(); tick(); #1;
    checks++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL wrap_ff: got %h expected ffffffff", retire_count);
    end
    tick(); #1;
    checks++;
    if (retire_count !== 32'd0) begin
      failures++; $display("FAIL wrap_zero: got %h expected 0", retire_count);
    end
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 5'(k + 1), 5'd1, 5'd2, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 66'd0) begin
      failures++; $display("FAIL async_reset: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    apply_nop();
    tick(); #1;
    checks++;
    if ({retire_count, wb_reg_write, mem_rd} !== {32'd0, 1'b0, 5'd0}) begin
      failures++; $display("FAIL reset_no_credit: got %h expected 0", {retire_count, wb_reg_write, mem_rd});
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_zero = 1'b0;
    apply_nop();
    model_clear();
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_use();
    test_forward();
    test_branch();
    test_stall_flush();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
